// File: rtl/score_disp_pkg.sv
// Shared types, glyph geometry and helpers for the target-score display.
// The level-to-score clamp and the decimal range limit live here for both modules.
package score_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    localparam int GLYPH_WORDS = 128;
    localparam int GLYPH_W     = 16;
    localparam int GLYPH_H     = 32;

    function automatic logic [63:0] clamp_score(input logic [63:0] prod, input int unsigned scoreW);
        logic [63:0] maxV;
        maxV = (64'd1 << scoreW) - 64'd1;
        return (prod > maxV) ? maxV : prod;
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3, one input bit per cycle.
// The bcd output only changes in DONE, so readers never see a partial result.
module bin2bcd_seq
    import score_disp_pkg::*;
#(
    parameter int SCORE_W = 20,
    parameter int DIGITS  = 5
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [SCORE_W-1:0]    bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BcdW = 4 * DIGITS;
    localparam int CntW = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
    localparam logic [SCORE_W-1:0] MaxVal   = SCORE_W'(pow10(DIGITS) - 64'd1);
    localparam logic [BcdW-1:0]    AllNines = {DIGITS{4'h9}};

    state_e              state_q;
    logic [SCORE_W-1:0]  shift_q;
    logic [BcdW-1:0]     scratch_q;
    logic [BcdW-1:0]     scratch_d;
    logic [BcdW-1:0]     adjusted;
    logic [CntW-1:0]     cnt_q;
    logic [BcdW-1:0]     bcd_q;
    logic                done_q;
    logic                ovf_q;
    logic [3:0]          nib;

    // Add 3 to every nibble that would reach 10 or more once doubled, then shift in the next bit.
    always_comb begin
        adjusted = '0;
        nib      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nib = scratch_q[4*i +: 4];
            adjusted[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
        scratch_d = BcdW'({adjusted, shift_q[SCORE_W-1]});
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_q   <= bin;
                        scratch_q <= '0;
                        cnt_q     <= '0;
                        ovf_q     <= (bin > MaxVal);
                        done_q    <= 1'b0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch_q <= scratch_d;
                    shift_q   <= shift_q << 1;
                    cnt_q     <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(SCORE_W - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    bcd_q   <= ovf_q ? AllNines : scratch_q;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/target_score_display.sv
// Level counter, saturating SCALE*level^2 score, BCD conversion and digit-box
// font addressing for the target screen; the glyph ROM sits downstream.
module target_score_display
    import score_disp_pkg::*;
#(
    parameter int DIGITS    = 5,
    parameter int SCORE_W   = 20,
    parameter int LEVEL_W   = 10,
    parameter int SCALE     = 80,
    parameter int MAX_LEVEL = 50,
    parameter int X0        = 180,
    parameter int Y0        = 200,
    parameter int PITCH     = 21,
    parameter bit LZ_BLANK  = 1'b0
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic                  display_target,
    input  logic [9:0]            DrawX,
    input  logic [9:0]            DrawY,
    output logic [LEVEL_W-1:0]    level,
    output logic [SCORE_W-1:0]    target_score,
    output logic [4*DIGITS-1:0]   bcd_digits,
    output logic                  bcd_valid,
    output logic [10:0]           font_addr,
    output logic                  digit_hit
);

    localparam int ProdW = 2 * LEVEL_W + 8;

    logic                  displayPrev_q;
    logic [LEVEL_W-1:0]    level_q;
    logic [LEVEL_W-1:0]    level_d;
    logic [SCORE_W-1:0]    targetScore_q;
    logic [SCORE_W-1:0]    targetScore_d;
    logic [SCORE_W-1:0]    lastConverted_q;
    logic [ProdW-1:0]      prod;
    logic                  convStart;
    logic                  convBusy;
    logic                  convDone;
    logic [4*DIGITS-1:0]   bcdDigits;
    logic [10:0]           fontAddr_q;
    logic [10:0]           fontAddr_d;
    logic [1:0]            hitPipe_q;
    logic                  hit_d;
    logic [9:0]            xk;
    logic [9:0]            dx;
    logic [9:0]            dy;
    logic [3:0]            digitNib;
    logic                  leadZero;

    always_comb begin
        level_d = level_q;
        if (display_target && !displayPrev_q && (level_q < LEVEL_W'(MAX_LEVEL))) begin
            level_d = level_q + LEVEL_W'(1);
        end
        prod          = ProdW'(level_q) * ProdW'(level_q) * ProdW'(SCALE);
        targetScore_d = SCORE_W'(clamp_score(64'(prod), SCORE_W));
    end

    // A new conversion is requested whenever the score differs from what was last handed over.
    assign convStart = (targetScore_q != lastConverted_q) && !convBusy;

    bin2bcd_seq #(
        .SCORE_W (SCORE_W),
        .DIGITS  (DIGITS)
    ) u_bin2bcd (
        .Clk   (Clk),
        .reset (reset),
        .start (convStart),
        .bin   (targetScore_q),
        .busy  (convBusy),
        .done  (convDone),
        .bcd   (bcdDigits)
    );

    // Boxes never overlap, so at most one digit claims the pixel; blanked digits keep their address.
    always_comb begin
        fontAddr_d = '0;
        hit_d      = 1'b0;
        xk         = '0;
        dx         = '0;
        dy         = DrawY - 10'(Y0);
        digitNib   = '0;
        leadZero   = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            xk       = 10'(X0 + k * PITCH);
            digitNib = bcdDigits[4*(DIGITS-1-k) +: 4];
            leadZero = leadZero && (digitNib == 4'd0);
            dx       = DrawX - xk;
            if ((DrawX >= xk) && (DrawX <= xk + 10'(GLYPH_W - 1)) &&
                (DrawY >= 10'(Y0)) && (DrawY <= 10'(Y0 + GLYPH_H - 1))) begin
                fontAddr_d = 11'(digitNib) * 11'(GLYPH_WORDS)
                           + 11'(dy >> 1) * 11'(GLYPH_W / 2)
                           + 11'(dx >> 1);
                hit_d      = !(LZ_BLANK && leadZero && (k < DIGITS - 1));
            end
        end
    end

    // The hit flag trails the address by one extra stage to line up with the ROM read data.
    always_ff @(posedge Clk) begin
        if (reset) begin
            displayPrev_q   <= 1'b0;
            level_q         <= '0;
            targetScore_q   <= '0;
            lastConverted_q <= '0;
            fontAddr_q      <= '0;
            hitPipe_q       <= '0;
        end else begin
            displayPrev_q <= display_target;
            level_q       <= level_d;
            targetScore_q <= targetScore_d;
            if (convStart) begin
                lastConverted_q <= targetScore_q;
            end
            fontAddr_q <= fontAddr_d;
            hitPipe_q  <= {hitPipe_q[0], hit_d};
        end
    end

    assign level        = level_q;
    assign target_score = targetScore_q;
    assign bcd_digits   = bcdDigits;
    assign bcd_valid    = convDone;
    assign font_addr    = fontAddr_q;
    assign digit_hit    = hitPipe_q[1];

endmodule

// File: doc/target_score_display.md
Name: target_score_display

Overview:
- Tracks the level-target score and renders it as on-screen digits.
- The level counter advances once per target-screen entry; score = SCALE*level².
- The score is converted to BCD sequentially (shift-add-3), with no dividers.
- Emits per-pixel font-ROM addresses and a digit-box hit flag for the pixel mux. It is the parametrised successor of the fixed 5-digit target-score logic and sits between game control and the colour mapper.

Parameters:
- DIGITS, 5, number of decimal digits displayed
- SCORE_W, 20, score width in bits; must satisfy 2^SCORE_W-1 ≥ 10^DIGITS-1
- LEVEL_W, 10, level counter width
- SCALE, 80, score multiplier
- MAX_LEVEL, 50, level saturation value
- X0, 180, left x of the most-significant digit
- Y0, 200, top y of the digit row
- PITCH, 21, x distance between digit origins
- LZ_BLANK, 0, 1 = suppress leading zeros (the least-significant digit is always shown)

Ports:
- Clk  in  1  system clock
- reset  in  1  synchronous, active-high
- display_target  in  1  high while the target screen is shown
- DrawX  in  10  current pixel x
- DrawY  in  10  current pixel y
- level  out  LEVEL_W  current level
- target_score  out  SCORE_W  registered SCALE*level², saturating
- bcd_digits  out  4*DIGITS  packed BCD; digit 0 is the MSD (top nibble)
- bcd_valid  out  1  bcd_digits matches target_score
- font_addr  out  11  glyph ROM address (128 words per glyph)
- digit_hit  out  1  pixel lies inside a shown digit box

Behaviour:
- Reset values: level=0, target_score=0, bcd_digits=0, bcd_valid=1, font_addr=0, digit_hit=0, FSM=IDLE.
- Level counting:
  - A rising edge of display_target (registered previous value, 0→1) increments level on the next cycle.
  - Exactly one increment per assertion, regardless of pulse length.
  - Saturates at MAX_LEVEL.
  - If reset and the edge occur in the same cycle, reset wins.
- Score:
  - target_score is registered one cycle after a level change.
  - The product is computed at 2*LEVEL_W+8 bits, then clamped to 2^SCORE_W-1.
- BCD FSM states:
  - IDLE: wait for target_score ≠ last_converted. On change, latch score into the shift register, clear scratch BCD, set bcd_valid=0, go to SHIFT.
  - SHIFT: one bit per cycle for SCORE_W cycles. Each cycle, add 3 to every scratch nibble ≥5, then shift left, taking in the score MSB. After the final bit go to DONE.
  - DONE: copy scratch to bcd_digits, set bcd_valid=1, update last_converted, go to IDLE.
- BCD latency: SCORE_W+2 cycles from the target_score change to bcd_valid=1.
- bcd_digits changes only in DONE (atomic). It holds the old value during conversion, so no partial digits are ever displayed.
- If target_score changes during SHIFT, finish the current conversion; IDLE then detects the mismatch and restarts.
- If target_score exceeds 10^DIGITS-1, all digits show 9.
- Digit box geometry:
  - Digit k (0..DIGITS-1) spans x ∈ [X0+k*PITCH, X0+k*PITCH+15] and y ∈ [Y0, Y0+31].
  - Glyphs are 8x16, doubled 2x.
- Address: font_addr = 128*d + ((DrawY-Y0)>>1)*8 + ((DrawX-xk)>>1), where d = displayed BCD nibble of digit k.
- Outside every box, or in the gaps between boxes: font_addr=0, digit_hit=0.
- Blanking: with LZ_BLANK=1, a leading-zero digit (all higher digits also zero, and k<DIGITS-1) gives digit_hit=0.
- Pixel-path latency:
  - font_addr is registered (1 cycle after DrawX/DrawY).
  - digit_hit is delayed 2 cycles so it aligns with the synchronous ROM output.
- Subtraction and comparison are unsigned on 10 bits. Boxes are assumed to lie fully on screen; there is no wrap-around.

Decomposition:
- Package score_disp_pkg:
  - state enum {IDLE, SHIFT, DONE}
  - GLYPH_WORDS=128
  - GLYPH_W=16, GLYPH_H=32
  - function clamp_score
- Sub-module bin2bcd_seq (parametrised SCORE_W, DIGITS):
  - contains the FSM
  - ports start, bin, busy, done, bcd
- The top level holds the level counter, score register and address generator. The glyph ROM stays outside this block.

Test Plan:
- Reset, then one display_target pulse of 40 cycles → level=1, target_score=80, bcd_digits=0x00080 after 22 cycles, with exactly one increment.
- Three separate pulses → level=3, target_score=720, bcd_digits=0x00720. bcd_valid must be low for 22 cycles after each change, and the old digits must be held meanwhile.
- Drive level to 12 → target_score=11520, bcd_digits=0x11520. Then apply 60 pulses → level saturates at 50, target_score=200000, digits=0x99999 (DIGITS=5 overflow).
- At level=2 (digits 00320), DrawX=222, DrawY=202 → font_addr=392 one cycle later, and digit_hit=1 two cycles after the pixel.
- LZ_BLANK=1, score 320, DrawX=180, DrawY=200 → digit_hit=0. DrawX=196 (gap) → font_addr=0, digit_hit=0.
- Assert reset mid-SHIFT → all outputs return to reset values next cycle, bcd_valid=1, and no DONE write occurs.
